// File: rtl/traffic_phase_sequencer.sv
// Eight-phase traffic cycle sequencer: road1 rests in green, road2 is served on latched demand.
// Prescaled per-phase dwell timing, sensor-driven road2 extension and a force-to-red override.
module traffic_phase_sequencer #(
   parameter int TICK_DIV    = 100,
   parameter int TW          = 8,
   parameter int T_ALLRED    = 2,
   parameter int T_GREEN_MIN = 10,
   parameter int T_YELLOW    = 3,
   parameter int T_GREEN2    = 5,
   parameter int T_EXT       = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic req2,
   input  logic sense2,
   input  logic force_red,
   output logic C0,
   output logic C1,
   output logic C2,
   output logic demand2,
   output logic tick
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

   localparam logic [TW-1:0] LD_ALLRED    = TW'(T_ALLRED - 1);
   localparam logic [TW-1:0] LD_GREEN_MIN = TW'(T_GREEN_MIN - 1);
   localparam logic [TW-1:0] LD_YELLOW    = TW'(T_YELLOW - 1);
   localparam logic [TW-1:0] LD_GREEN2    = TW'(T_GREEN2 - 1);
   localparam logic [TW-1:0] LD_EXT       = TW'(T_EXT - 1);

   typedef enum logic [2:0] {
      PH_RED_A     = 3'd0,
      PH_GRN1_MIN  = 3'd1,
      PH_GRN1_REST = 3'd2,
      PH_YEL1      = 3'd3,
      PH_RED_B     = 3'd4,
      PH_GRN2_BASE = 3'd5,
      PH_GRN2_EXT  = 3'd6,
      PH_YEL2      = 3'd7
   } phase_t;

   phase_t          phase_q, phase_d;
   logic [PW-1:0]   presc_q;
   logic [TW-1:0]   dwell_q, dwell_d;
   logic            demand_q, demand_d;
   logic            expire;
   logic            entering;

   assign tick     = en && (presc_q == PRESC_LAST);
   assign expire   = tick && (dwell_q == '0);
   assign entering = (phase_d != phase_q);

   assign {C2, C1, C0} = phase_q;
   assign demand2      = demand_q;

   // Dwell reload value for the phase being entered; the resting green is untimed.
   function automatic logic [TW-1:0] load_for(input phase_t p);
      load_for = '0;
      case (p)
         PH_RED_A, PH_RED_B: load_for = LD_ALLRED;
         PH_GRN1_MIN:        load_for = LD_GREEN_MIN;
         PH_YEL1, PH_YEL2:   load_for = LD_YELLOW;
         PH_GRN2_BASE:       load_for = LD_GREEN2;
         PH_GRN2_EXT:        load_for = LD_EXT;
         default:            load_for = '0;
      endcase
   endfunction

   always_comb begin
      // NOTE: each combinational output is given a default before any branch, so no path infers a latch.
      phase_d = phase_q;
      if (en) begin
         unique case (phase_q)
            PH_RED_A:     if (!force_red && expire) phase_d = PH_GRN1_MIN;
            PH_GRN1_MIN:  if (force_red) phase_d = PH_YEL1;
                          else if (expire) phase_d = PH_GRN1_REST;
            PH_GRN1_REST: if (force_red || (tick && demand_q)) phase_d = PH_YEL1;
            PH_YEL1:      if (expire) phase_d = PH_RED_B;
            PH_RED_B:     if (!force_red && expire) phase_d = PH_GRN2_BASE;
            PH_GRN2_BASE: if (force_red) phase_d = PH_YEL2;
                          else if (expire) phase_d = PH_GRN2_EXT;
            PH_GRN2_EXT:  if (force_red || (tick && (!sense2 || dwell_q == '0))) phase_d = PH_YEL2;
            PH_YEL2:      if (expire) phase_d = PH_RED_A;
         endcase
      end
   end

   // Holding in an all-red phase saturates the counter at zero, so release waits for one tick.
   always_comb begin
      dwell_d = dwell_q;
      if (entering)
         dwell_d = load_for(phase_d);
      else if (tick && dwell_q != '0)
         dwell_d = dwell_q - TW'(1);
   end

   // Entry into road2 green consumes the demand; that clear beats a same-clock request.
   always_comb begin
      demand_d = demand_q;
      if (entering && phase_d == PH_GRN2_BASE)
         demand_d = 1'b0;
      else if (req2)
         demand_d = 1'b1;
   end

   // NOTE: registers use non-blocking assignments so every update sees the pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_q  <= PH_RED_A;
         presc_q  <= '0;
         dwell_q  <= LD_ALLRED;
         demand_q <= 1'b0;
      end else if (en) begin
         presc_q  <= (presc_q == PRESC_LAST) ? '0 : presc_q + PW'(1);
         phase_q  <= phase_d;
         dwell_q  <= dwell_d;
         demand_q <= demand_d;
      end
   end

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Self-checking bench for traffic_phase_sequencer: directed scenarios plus a randomized run
// compared cycle by cycle against a rule-level phase model.
module tb_traffic_phase_sequencer;

   localparam int TD  = 4;
   localparam int TW  = 8;
   localparam int TA  = 2;
   localparam int TG  = 3;
   localparam int TY  = 2;
   localparam int TG2 = 3;
   localparam int TE  = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic en = 1'b1;
   logic req2 = 1'b0;
   logic sense2 = 1'b0;
   logic force_red = 1'b0;
   logic c0, c1, c2, demand2, tick;
   logic [2:0] code;

   int total = 0;
   int bad = 0;

   // Model: phase, ticks still to dwell (including the current one), clock position in the tick period.
   int m_phase, m_rem, m_div;
   bit m_dem;

   assign code = {c2, c1, c0};

   always #5 clk = ~clk;

   traffic_phase_sequencer #(
      .TICK_DIV(TD), .TW(TW), .T_ALLRED(TA), .T_GREEN_MIN(TG),
      .T_YELLOW(TY), .T_GREEN2(TG2), .T_EXT(TE)
   ) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .req2(req2), .sense2(sense2),
      .force_red(force_red), .C0(c0), .C1(c1), .C2(c2),
      .demand2(demand2), .tick(tick)
   );

   function automatic int dur(input int p);
      case (p)
         0, 4:    return TA;
         1:       return TG;
         3, 7:    return TY;
         5:       return TG2;
         6:       return TE;
         default: return 1;
      endcase
   endfunction

   task automatic model_reset();
      m_phase = 0;
      m_rem   = TA;
      m_div   = 0;
      m_dem   = 1'b0;
   endtask

   task automatic model_step();
      bit t, ex;
      int nx;
      if (!en) return;
      t  = (m_div == TD - 1);
      ex = t && (m_rem == 1);
      nx = m_phase;
      case (m_phase)
         0: if (!force_red && ex) nx = 1;
         1: if (force_red) nx = 3; else if (ex) nx = 2;
         2: if (force_red || (t && m_dem)) nx = 3;
         3: if (ex) nx = 4;
         4: if (!force_red && ex) nx = 5;
         5: if (force_red) nx = 7; else if (ex) nx = 6;
         6: if (force_red || (t && (!sense2 || m_rem == 1))) nx = 7;
         default: if (ex) nx = 0;
      endcase
      if (nx != m_phase) m_rem = dur(nx);
      else if (t && m_rem > 1) m_rem = m_rem - 1;
      if (nx == 5 && m_phase != 5) m_dem = 1'b0;
      else if (req2) m_dem = 1'b1;
      m_phase = nx;
      m_div   = (m_div + 1) % TD;
   endtask

   // One clock: model and DUT both consume the inputs present at the edge; sample 1 time unit later.
   task automatic cyc();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic run_to(input int p);
      int k = 0;
      while (code !== 3'(p) && k < 400) begin
         cyc();
         k++;
      end
      total++;
      if (code !== 3'(p)) begin
         bad++;
         $display("FAIL run_to_phase_%0d: phase=%0d after %0d clocks", p, code, k);
      end
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      #1;
      total++;
      if (code !== 3'd0) begin bad++; $display("FAIL reset_phase: got %0d want 0", code); end
      total++;
      if (demand2 !== 1'b0) begin bad++; $display("FAIL reset_demand2: got %b want 0", demand2); end
      total++;
      if (tick !== 1'b0) begin bad++; $display("FAIL reset_tick: got %b want 0", tick); end
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_sequence();
      int exp_dwell [8] = '{8, 12, 4, 8, 8, 12, 4, 8};
      int n;
      int stray;
      sense2 = 1'b0;
      stray  = 0;
      for (int p = 0; p < 8; p++) begin
         n = 0;
         do begin
            req2 = (p == 1 && n == 0);
            cyc();
            n++;
            if (code !== m_phase[2:0] || demand2 !== m_dem) stray++;
         end while (code === 3'(p) && n < 100);
         req2 = 1'b0;
         total++;
         if (n != exp_dwell[p] || code !== 3'((p + 1) % 8)) begin
            bad++;
            $display("FAIL dwell_phase_%0d: got %0d clocks then phase %0d, want %0d clocks",
                     p, n, code, exp_dwell[p]);
         end
         if (p == 3) begin
            total++;
            if (demand2 !== 1'b1) begin bad++; $display("FAIL demand2_held: got %b want 1", demand2); end
         end
         if (p == 4) begin
            total++;
            if (demand2 !== 1'b0) begin bad++; $display("FAIL demand2_clear_at_5: got %b want 0", demand2); end
         end
      end
      total++;
      if (stray != 0) begin bad++; $display("FAIL sequence_vs_model: %0d differing clocks, want 0", stray); end
   endtask

   task automatic test_no_demand();
      int stray = 0;
      run_to(2);
      for (int i = 0; i < 1000; i++) begin
         cyc();
         if (code !== 3'd2 || demand2 !== 1'b0) stray++;
      end
      total++;
      if (stray != 0) begin bad++; $display("FAIL rest_in_green: %0d clocks left phase 2, want 0", stray); end
   endtask

   task automatic test_extension();
      int drop_at [2] = '{99, 6};
      int exp_len [2] = '{16, 8};
      int n;
      for (int t = 0; t < 2; t++) begin
         run_to(2);
         req2 = 1'b1;
         cyc();
         req2 = 1'b0;
         sense2 = 1'b1;
         run_to(6);
         n = 0;
         do begin
            if (n == drop_at[t]) sense2 = 1'b0;
            cyc();
            n++;
         end while (code === 3'd6 && n < 100);
         sense2 = 1'b0;
         total++;
         if (n != exp_len[t] || code !== 3'd7) begin
            bad++;
            $display("FAIL extension_%0d: got %0d clocks then phase %0d, want %0d then 7", t, n, code, exp_len[t]);
         end
      end
   endtask

   task automatic test_force_red();
      int k = 0;
      int stray = 0;
      bit pt, early;
      run_to(1);
      while (!tick && k < 10) begin
         cyc();
         k++;
      end
      force_red = 1'b1;
      cyc();
      total++;
      if (code !== 3'd3) begin bad++; $display("FAIL force_to_yellow: got %0d want 3", code); end
      for (int i = 1; i <= 8; i++) begin
         cyc();
         if (i == 7) begin
            total++;
            if (code !== 3'd3) begin bad++; $display("FAIL yellow_kept: got %0d want 3", code); end
         end
      end
      total++;
      if (code !== 3'd4) begin bad++; $display("FAIL yellow_to_allred: got %0d want 4", code); end
      for (int i = 0; i < 20 + int'($urandom_range(0, 3)); i++) begin
         cyc();
         if (code !== 3'd4) stray++;
      end
      total++;
      if (stray != 0) begin bad++; $display("FAIL allred_hold: %0d clocks off phase 4, want 0", stray); end
      force_red = 1'b0;
      k = 0;
      early = 1'b0;
      do begin
         pt = tick;
         cyc();
         k++;
         if (code === 3'd4 && pt) early = 1'b1;
      end while (code === 3'd4 && k < 20);
      total++;
      if (code !== 3'd5 || !pt || early) begin
         bad++;
         $display("FAIL release_at_tick: phase=%0d tick_before=%b missed_tick=%b, want 5/1/0", code, pt, early);
      end
   endtask

   task automatic test_enable();
      logic [2:0] snap_c;
      logic snap_d;
      int stray = 0;
      int n = 5;
      repeat (5) cyc();
      snap_c = code;
      snap_d = demand2;
      en   = 1'b0;
      req2 = 1'b1;
      for (int i = 0; i < 50; i++) begin
         cyc();
         if (code !== snap_c || demand2 !== snap_d || tick !== 1'b0) stray++;
      end
      total++;
      if (stray != 0) begin bad++; $display("FAIL freeze: %0d clocks changed while en=0, want 0", stray); end
      en   = 1'b1;
      req2 = 1'b0;
      do begin
         cyc();
         n++;
      end while (code === 3'd5 && n < 100);
      total++;
      if (n != 12 || code !== 3'd6) begin
         bad++;
         $display("FAIL resume_dwell: phase 5 ran %0d enabled clocks then %0d, want 12 then 6", n, code);
      end
   endtask

   task automatic test_async_reset();
      int k = 0;
      bit applied = 1'b0;
      run_to(6);
      req2 = 1'b1;
      cyc();
      req2 = 1'b0;
      total++;
      if (code !== 3'd6 || demand2 !== 1'b1) begin
         bad++;
         $display("FAIL demand_in_6: phase=%0d demand2=%b want 6/1", code, demand2);
      end
      #3 rst_n = 1'b0;
      #1;
      total++;
      if (code !== 3'd0 || demand2 !== 1'b0) begin
         bad++;
         $display("FAIL async_reset: phase=%0d demand2=%b want 0/0", code, demand2);
      end
      #1 rst_n = 1'b1;
      model_reset();
      run_to(1);
      req2 = 1'b1;
      cyc();
      req2 = 1'b0;
      run_to(4);
      while (code === 3'd4 && k < 100) begin
         req2 = (tick && m_rem == 1);
         if (req2) applied = 1'b1;
         cyc();
         k++;
      end
      req2 = 1'b0;
      total++;
      if (code !== 3'd5 || demand2 !== 1'b0 || !applied) begin
         bad++;
         $display("FAIL req_on_entry_5: phase=%0d demand2=%b req_applied=%b want 5/0/1", code, demand2, applied);
      end
   endtask

   task automatic test_random();
      bit exp_tick;
      for (int i = 0; i < 4000; i++) begin
         en   = ($urandom_range(0, 9) != 0);
         req2 = ($urandom_range(0, 24) == 0);
         if ($urandom_range(0, 15) == 0) sense2 = ~sense2;
         if ($urandom_range(0, 79) == 0) force_red = ~force_red;
         cyc();
         exp_tick = en && (m_div == TD - 1);
         total++;
         if (code !== m_phase[2:0] || demand2 !== m_dem || tick !== exp_tick) begin
            bad++;
            $display("FAIL random_%0d: phase=%0d demand2=%b tick=%b want %0d/%b/%b",
                     i, code, demand2, tick, m_phase, m_dem, exp_tick);
         end
      end
      en = 1'b1;
      force_red = 1'b0;
      req2 = 1'b0;
   endtask

   initial begin
      model_reset();
      test_reset();
      test_sequence();
      test_no_demand();
      test_extension();
      test_force_red();
      test_enable();
      test_async_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
